// File: rtl/mtimer_pkg.sv
// Shared constants for the machine-timer peripheral: register offsets, CTRL bits,
// load/store width codes and the lane-merge helper used by byte/half stores.
package mtimer_pkg;

   localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
   localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
   localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
   localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
   localparam logic [2:0] OFF_CTRL        = 3'd4;
   localparam logic [2:0] OFF_PRESCALE    = 3'd5;
   localparam logic [2:0] OFF_STATUS      = 3'd6;

   localparam int unsigned CTRL_EN       = 0;
   localparam int unsigned CTRL_IRQ_EN   = 1;
   localparam int unsigned CTRL_PERIODIC = 2;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                               input logic [31:0] lane_data,
                                               input logic [3:0]  be);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = be[i] ? lane_data[8*i +: 8] : old_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Prescale counter: while enabled, counts up and wraps to 0 on reaching the prescale
// value, emitting a one-cycle tick on the wrapping cycle.
module mtimer_prescaler #(
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  clr,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] cnt_q, cnt_d;

   assign tick = en & (cnt_q == prescale);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mtimer_resp.sv
// Memory-mapped machine timer on the MW-stage load/store bus: 64-bit mtime/mtimecmp,
// prescaled tick, one-shot or periodic compare, and a W1C pending flag driving intr_exc.
module mtimer_resp
   import mtimer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [2:0]  func3,
   output logic        hit,
   output logic [31:0] rdata,
   output logic        intr_exc
);

   logic [63:0]           mtime_q, mtime_d;
   logic [63:0]           mtimecmp_q, mtimecmp_d;
   logic [31:0]           ctrl_q, ctrl_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic                  pending_q, pending_d;
   logic [31:0]           hi_shadow_q, hi_shadow_d;

   logic [2:0]  off;
   logic [3:0]  be;
   logic [31:0] wlane;
   logic        wr_hit;
   logic [7:0]  wr_sel;
   logic        tick;
   logic        en, periodic, cmp_eq, pend_set, w1c;
   logic [31:0] rd_word;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   assign off      = addr[4:2];
   assign hit      = (addr[31:5] == BASE_ADDR[31:5]);
   assign en       = ctrl_q[CTRL_EN];
   assign periodic = ctrl_q[CTRL_PERIODIC];
   assign cmp_eq   = (mtime_q == mtimecmp_q);

   // Replicate store data across lanes so the byte enables alone pick the target bytes.
   always_comb begin
      be    = 4'b0000;
      wlane = wdata;
      case (func3)
         F3_B: begin
            be    = 4'b0001 << addr[1:0];
            wlane = {4{wdata[7:0]}};
         end
         F3_H: begin
            be    = addr[1] ? 4'b1100 : 4'b0011;
            wlane = {2{wdata[15:0]}};
         end
         F3_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   assign wr_hit = hit & wr_en & (|be);
   assign wr_sel = wr_hit ? (8'b0000_0001 << off) : 8'b0000_0000;
   assign w1c    = wr_sel[OFF_STATUS] & be[0] & wlane[0];

   mtimer_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .prescale (prescale_q),
      .clr      (wr_sel[OFF_PRESCALE]),
      .tick     (tick)
   );

   assign pend_set = periodic ? (tick & cmp_eq) : (en & (mtime_q >= mtimecmp_q));

   always_comb begin
      mtime_d     = mtime_q;
      mtimecmp_d  = mtimecmp_q;
      ctrl_d      = ctrl_q;
      prescale_d  = prescale_q;
      hi_shadow_d = hi_shadow_q;
      pending_d   = pend_set | (pending_q & ~w1c);

      // A software write to either mtime half suppresses that cycle's increment.
      if (wr_sel[OFF_MTIME_LO]) begin
         mtime_d[31:0] = merge_lanes(mtime_q[31:0], wlane, be);
      end else if (wr_sel[OFF_MTIME_HI]) begin
         mtime_d[63:32] = merge_lanes(mtime_q[63:32], wlane, be);
      end else if (tick) begin
         mtime_d = (periodic && cmp_eq) ? 64'd0 : mtime_q + 64'd1;
      end

      if (wr_sel[OFF_MTIMECMP_LO]) begin
         mtimecmp_d[31:0] = merge_lanes(mtimecmp_q[31:0], wlane, be);
      end
      if (wr_sel[OFF_MTIMECMP_HI]) begin
         mtimecmp_d[63:32] = merge_lanes(mtimecmp_q[63:32], wlane, be);
      end
      if (wr_sel[OFF_CTRL]) begin
         ctrl_d = merge_lanes(ctrl_q, wlane, be);
      end
      if (wr_sel[OFF_PRESCALE]) begin
         for (int i = 0; i < PRESCALE_W; i++) begin
            if (be[i/8]) prescale_d[i] = wlane[i];
         end
      end

      // Latch the upper half on a low-half read so a following high read is coherent.
      if (hit && rd_en && (off == OFF_MTIME_LO)) begin
         hi_shadow_d = mtime_q[63:32];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mtime_q     <= '0;
         mtimecmp_q  <= MTIMECMP_RST;
         ctrl_q      <= '0;
         prescale_q  <= '0;
         pending_q   <= 1'b0;
         hi_shadow_q <= '0;
      end else begin
         mtime_q     <= mtime_d;
         mtimecmp_q  <= mtimecmp_d;
         ctrl_q      <= ctrl_d;
         prescale_q  <= prescale_d;
         pending_q   <= pending_d;
         hi_shadow_q <= hi_shadow_d;
      end
   end

   assign intr_exc = pending_q & ctrl_q[CTRL_IRQ_EN];

   always_comb begin
      rd_word = '0;
      case (off)
         OFF_MTIME_LO:    rd_word = mtime_q[31:0];
         OFF_MTIME_HI:    rd_word = hi_shadow_q;
         OFF_MTIMECMP_LO: rd_word = mtimecmp_q[31:0];
         OFF_MTIMECMP_HI: rd_word = mtimecmp_q[63:32];
         OFF_CTRL:        rd_word = ctrl_q;
         OFF_PRESCALE:    rd_word = 32'(prescale_q);
         OFF_STATUS:      rd_word = {31'b0, pending_q};
         default:         rd_word = '0;
      endcase
   end

   assign rd_byte = rd_word[{addr[1:0], 3'b000} +: 8];
   assign rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      rdata = '0;
      if (hit && rd_en) begin
         case (func3)
            F3_B:    rdata = {{24{rd_byte[7]}}, rd_byte};
            F3_BU:   rdata = {24'b0, rd_byte};
            F3_H:    rdata = {{16{rd_half[15]}}, rd_half};
            F3_HU:   rdata = {16'b0, rd_half};
            default: rdata = rd_word;
         endcase
      end
   end

endmodule

// File: tb/tb_mtimer_resp.sv
// Bench for mtimer_resp: directed scenarios with literal expectations, then random bus
// traffic, all outputs compared every cycle against a register-level model.
module tb_mtimer_resp;
   import mtimer_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_0400;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        wr_en;
   logic        rd_en;
   logic [2:0]  func3;
   logic        hit;
   logic [31:0] rdata;
   logic        intr_exc;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mtimer_resp #(
      .BASE_ADDR  (BASE),
      .PRESCALE_W (16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .addr     (addr),
      .wdata    (wdata),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .func3    (func3),
      .hit      (hit),
      .rdata    (rdata),
      .intr_exc (intr_exc)
   );

   // Model state: the architectural registers as software sees them.
   logic [63:0] m_mt, m_cmp;
   logic [31:0] m_ctrl, m_shadow;
   logic [15:0] m_pre, m_cnt;
   logic        m_pend;
   logic        m_valid = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] put(input logic [31:0] old, input int a, input int n,
                                       input logic [31:0] d);
      logic [31:0] w;
      w = old;
      for (int b = 0; b < 4; b++) begin
         if (b >= a && b < a + n) w[8*b +: 8] = d[8*(b-a) +: 8];
      end
      return w;
   endfunction

   function automatic int wsize(input logic [2:0] f3);
      case (f3)
         3'b000:  return 1;
         3'b001:  return 2;
         3'b010:  return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] model_rdata();
      logic [31:0] word, sh;
      int a;
      if (!(addr[31:5] == BASE[31:5] && rd_en)) return 32'h0;
      case (addr[4:2])
         3'd0:    word = m_mt[31:0];
         3'd1:    word = m_shadow;
         3'd2:    word = m_cmp[31:0];
         3'd3:    word = m_cmp[63:32];
         3'd4:    word = m_ctrl;
         3'd5:    word = {16'h0, m_pre};
         3'd6:    word = {31'h0, m_pend};
         default: word = 32'h0;
      endcase
      a  = int'(addr[1:0]);
      sh = word >> (8 * a);
      case (func3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b100:  return {24'h0, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b101:  return {16'h0, sh[15:0]};
         default: return word;
      endcase
   endfunction

   task automatic model_step();
      logic [63:0] n_mt, n_cmp;
      logic [31:0] n_ctrl, tmp;
      logic [15:0] n_pre, n_cnt;
      bit inwin, wr, en, per, tick, set, w1c;
      int o, a, ws;
      if (reset) begin
         m_mt     <= 64'h0;
         m_cmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
         m_ctrl   <= 32'h0;
         m_pre    <= 16'h0;
         m_cnt    <= 16'h0;
         m_pend   <= 1'b0;
         m_shadow <= 32'h0;
         m_valid  <= 1'b1;
         return;
      end
      inwin = (addr[31:5] == BASE[31:5]);
      o     = int'(addr[4:2]);
      a     = int'(addr[1:0]);
      ws    = wsize(func3);
      wr    = inwin && wr_en && ws > 0;
      en    = m_ctrl[0];
      per   = m_ctrl[2];
      tick  = en && (m_cnt == m_pre);
      set   = per ? (tick && m_mt == m_cmp) : (en && m_mt >= m_cmp);
      w1c   = wr && o == 6 && a == 0 && wdata[0];
      n_mt  = m_mt;
      n_cmp = m_cmp;
      n_ctrl = m_ctrl;
      n_pre = m_pre;
      n_cnt = m_cnt;
      if (wr && o == 0)      n_mt[31:0] = put(m_mt[31:0], a, ws, wdata);
      else if (wr && o == 1) n_mt[63:32] = put(m_mt[63:32], a, ws, wdata);
      else if (tick)         n_mt = (per && m_mt == m_cmp) ? 64'h0 : m_mt + 64'h1;
      if (wr && o == 2) n_cmp[31:0] = put(m_cmp[31:0], a, ws, wdata);
      if (wr && o == 3) n_cmp[63:32] = put(m_cmp[63:32], a, ws, wdata);
      if (wr && o == 4) n_ctrl = put(m_ctrl, a, ws, wdata);
      if (wr && o == 5) begin
         tmp   = put({16'h0, m_pre}, a, ws, wdata);
         n_pre = tmp[15:0];
         n_cnt = 16'h0;
      end else if (en) begin
         n_cnt = tick ? 16'h0 : m_cnt + 16'h1;
      end
      if (inwin && rd_en && o == 0) m_shadow <= m_mt[63:32];
      m_mt   <= n_mt;
      m_cmp  <= n_cmp;
      m_ctrl <= n_ctrl;
      m_pre  <= n_pre;
      m_cnt  <= n_cnt;
      m_pend <= set || (m_pend && !w1c);
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      if (m_valid) begin
         chk("hit", {31'h0, hit}, {31'h0, addr[31:5] == BASE[31:5]});
         chk("rdata", rdata, model_rdata());
         chk("intr_exc", {31'h0, intr_exc}, {31'h0, m_pend & m_ctrl[1]});
      end
   end

   function automatic logic [31:0] ra(input logic [2:0] off, input logic [1:0] lane);
      return BASE | {27'h0, off, lane};
   endfunction

   task automatic drive(input logic [31:0] ad, input logic [31:0] wd, input logic we,
                        input logic re, input logic [2:0] f3);
      @(posedge clk);
      #1;
      addr  = ad;
      wdata = wd;
      wr_en = we;
      rd_en = re;
      func3 = f3;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(32'h0, 32'h0, 1'b0, 1'b0, F3_W);
   endtask

   task automatic wr(input logic [2:0] off, input logic [31:0] d);
      drive(ra(off, 2'd0), d, 1'b1, 1'b0, F3_W);
   endtask

   task automatic rd_chk(input string nm, input logic [31:0] ad, input logic [2:0] f3,
                         input logic [31:0] exp);
      drive(ad, 32'h0, 1'b0, 1'b1, f3);
      @(negedge clk);
      chk(nm, rdata, exp);
   endtask

   task automatic intr_chk(input string nm, input logic exp);
      idle(1);
      @(negedge clk);
      chk(nm, {31'h0, intr_exc}, {31'h0, exp});
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      addr  = 32'h0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   logic [2:0]  wf[3] = '{F3_B, F3_H, F3_W};
   logic [2:0]  rf[5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

   initial begin
      logic [2:0]  r_off, r_f3;
      logic [1:0]  r_lane;
      logic [31:0] r_d, r_ad;
      logic        r_we, r_re;

      reset = 1'b1;
      addr  = 32'h0;
      wdata = 32'h0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      func3 = F3_W;
      @(posedge clk);
      #1;
      reset = 1'b0;

      // One-shot compare, W1C, re-arm at 100.
      wr(OFF_PRESCALE, 32'd0);
      wr(OFF_MTIMECMP_LO, 32'd10);
      wr(OFF_MTIMECMP_HI, 32'd0);
      wr(OFF_CTRL, 32'd3);
      idle(20);
      intr_chk("t1_intr_set", 1'b1);
      rd_chk("t1_status", ra(OFF_STATUS, 2'd0), F3_W, 32'd1);
      wr(OFF_MTIMECMP_LO, 32'd100);
      wr(OFF_STATUS, 32'd1);
      intr_chk("t1_intr_clr", 1'b0);
      idle(90);
      intr_chk("t1_intr_rearm", 1'b1);

      // Prescale 3: one increment per four cycles.
      do_reset();
      wr(OFF_PRESCALE, 32'd3);
      wr(OFF_CTRL, 32'd1);
      idle(40);
      rd_chk("t2_mtime_40", ra(OFF_MTIME_LO, 2'd0), F3_W, 32'd10);

      // Carry into the high word and shadowed high reads.
      do_reset();
      wr(OFF_MTIME_LO, 32'hFFFF_FFFF);
      wr(OFF_MTIME_HI, 32'h0);
      wr(OFF_CTRL, 32'd1);
      wr(OFF_CTRL, 32'd0);
      rd_chk("t3_hi_before_lo", ra(OFF_MTIME_HI, 2'd0), F3_W, 32'd0);
      rd_chk("t3_lo", ra(OFF_MTIME_LO, 2'd0), F3_W, 32'd0);
      rd_chk("t3_hi", ra(OFF_MTIME_HI, 2'd0), F3_W, 32'd1);
      wr(OFF_MTIME_HI, 32'd5);
      rd_chk("t3_hi_stale", ra(OFF_MTIME_HI, 2'd0), F3_W, 32'd1);
      rd_chk("t3_lo2", ra(OFF_MTIME_LO, 2'd0), F3_W, 32'd0);
      rd_chk("t3_hi_new", ra(OFF_MTIME_HI, 2'd0), F3_W, 32'd5);

      // Periodic mode wraps at mtimecmp.
      do_reset();
      wr(OFF_MTIMECMP_LO, 32'd4);
      wr(OFF_MTIMECMP_HI, 32'd0);
      wr(OFF_CTRL, 32'd7);
      for (int i = 0; i < 12; i++) begin
         rd_chk("t4_seq", ra(OFF_MTIME_LO, 2'd0), F3_W, 32'(i % 5));
      end
      wr(OFF_STATUS, 32'd1);
      intr_chk("t4_clr_a", 1'b0);
      intr_chk("t4_clr_b", 1'b0);
      intr_chk("t4_reset_on_wrap", 1'b1);

      // Byte lanes, sign extension, out-of-window access.
      do_reset();
      wr(OFF_CTRL, 32'h1200_0000);
      drive(ra(OFF_CTRL, 2'd1), 32'h0000_00A5, 1'b1, 1'b0, F3_B);
      rd_chk("t5_lb", ra(OFF_CTRL, 2'd1), F3_B, 32'hFFFF_FFA5);
      rd_chk("t5_lbu", ra(OFF_CTRL, 2'd1), F3_BU, 32'h0000_00A5);
      rd_chk("t5_lw", ra(OFF_CTRL, 2'd0), F3_W, 32'h1200_A500);
      rd_chk("t5_lh_hi", ra(OFF_CTRL, 2'd2), F3_H, 32'h0000_1200);
      drive(BASE + 32'h20, 32'hDEAD_BEEF, 1'b1, 1'b1, F3_W);
      @(negedge clk);
      chk("t5_oow_hit", {31'h0, hit}, 32'd0);
      chk("t5_oow_rdata", rdata, 32'd0);
      rd_chk("t5_mtime_untouched", ra(OFF_MTIME_LO, 2'd0), F3_W, 32'd0);
      rd_chk("t5_ctrl_untouched", ra(OFF_CTRL, 2'd0), F3_W, 32'h1200_A500);

      // Write beats tick, set beats W1C, reset mid-count.
      do_reset();
      wr(OFF_CTRL, 32'd1);
      idle(5);
      wr(OFF_MTIME_LO, 32'd7);
      rd_chk("t6_sw_wins", ra(OFF_MTIME_LO, 2'd0), F3_W, 32'd7);
      wr(OFF_MTIMECMP_LO, 32'd0);
      wr(OFF_MTIMECMP_HI, 32'd0);
      idle(2);
      wr(OFF_STATUS, 32'd1);
      rd_chk("t6_set_wins", ra(OFF_STATUS, 2'd0), F3_W, 32'd1);
      wr(OFF_PRESCALE, 32'd2);
      wr(OFF_CTRL, 32'd3);
      idle(9);
      do_reset();
      rd_chk("t6_rst_lo", ra(OFF_MTIME_LO, 2'd0), F3_W, 32'd0);
      rd_chk("t6_rst_hi", ra(OFF_MTIME_HI, 2'd0), F3_W, 32'd0);
      rd_chk("t6_rst_cmplo", ra(OFF_MTIMECMP_LO, 2'd0), F3_W, 32'hFFFF_FFFF);
      rd_chk("t6_rst_cmphi", ra(OFF_MTIMECMP_HI, 2'd0), F3_W, 32'hFFFF_FFFF);
      rd_chk("t6_rst_ctrl", ra(OFF_CTRL, 2'd0), F3_W, 32'd0);
      rd_chk("t6_rst_pre", ra(OFF_PRESCALE, 2'd0), F3_W, 32'd0);
      rd_chk("t6_rst_status", ra(OFF_STATUS, 2'd0), F3_W, 32'd0);
      intr_chk("t6_rst_intr", 1'b0);

      // Random traffic, checked cycle by cycle against the model.
      for (int i = 0; i < 3000; i++) begin
         r_we  = ($urandom_range(0, 2) == 0);
         r_re  = ($urandom_range(0, 1) == 0);
         r_off = 3'($urandom_range(0, 7));
         r_f3  = r_we ? wf[$urandom_range(0, 2)] : rf[$urandom_range(0, 4)];
         if (r_off == OFF_PRESCALE && r_we) r_f3 = F3_W;
         case (r_f3)
            F3_B, F3_BU: r_lane = 2'($urandom_range(0, 3));
            F3_H, F3_HU: r_lane = {1'($urandom_range(0, 1)), 1'b0};
            default:     r_lane = 2'd0;
         endcase
         r_d = $urandom;
         if (r_off == OFF_PRESCALE) r_d = $urandom_range(0, 3);
         if ((r_off == OFF_MTIME_LO || r_off == OFF_MTIMECMP_LO) && $urandom_range(0, 1) == 1)
            r_d = $urandom_range(0, 40);
         if ((r_off == OFF_MTIME_HI || r_off == OFF_MTIMECMP_HI) && $urandom_range(0, 3) != 0)
            r_d = 32'h0;
         r_ad = ra(r_off, r_lane);
         if ($urandom_range(0, 11) == 0) r_ad = r_ad ^ (32'h20 << $urandom_range(0, 26));
         @(posedge clk);
         #1;
         reset = ($urandom_range(0, 399) == 0);
         addr  = r_ad;
         wdata = r_d;
         wr_en = r_we;
         rd_en = r_re;
         func3 = r_f3;
      end
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
